conv1d_pe_stream: RTL and testbench
===================================

// Module: conv1d_pe_stream
// PURPOSE
//  Parametrised streaming 1-D convolution PE, successor to the fixed 7-tap MAC-chain PE in the ECG CNN datapath.
//  Holds K runtime-loadable weights and a K-deep sample window, and emits one output per accepted sample.
//  Each output is bias + dot(window, weights), followed by round, saturate and optional ReLU.
//  Valid/ready on both the input and output streams; the output feeds the pooling/activation stage.
// PARAMETERS
//  DW     16          sample/weight/bias width, signed two's complement
//  K      7           tap count, >=2
//  GUARD  4           accumulator guard bits; ACC_W = 2*DW+GUARD; GUARD >= clog2(K)+1
//  FRAC   8           output right-shift (fixed-point scaling), 0..ACC_W-2
//  OUT_W  16          output width, signed
// PORTS
//  clk       in   1          clock, rising edge
//  rst       in   1          reset, asynchronous, active-high
//  flush     in   1          synchronous clear of window, fill count, pipeline valids
//  w_load    in   1          weight write strobe
//  w_idx     in   clog2(K)   tap index written (0 = newest-sample tap)
//  w_data    in   DW         weight value
//  bias      in   DW         bias, sampled at acceptance with the sample
//  relu_en   in   1          1: negative outputs forced to 0
//  s_valid   in   1          input sample valid
//  s_ready   out  1          PE can accept a sample
//  s_data    in   DW         input sample
//  m_valid   out  1          output valid
//  m_ready   in   1          downstream accepts output
//  m_data    out  OUT_W      result
//  m_sat     out  1          saturation occurred on m_data (qualified by m_valid)
// BEHAVIOUR
//  Reset: all outputs 0. Weights, window, fill counter and stage valids are 0.
//  Flush: clears window, fill counter and stage valids. Weights are kept.
//  Accept: acc = s_valid && s_ready.
//  Stall: stall = m_valid && !m_ready. adv = !stall.
//  s_ready = adv && !w_load && !flush.
//  Weights: w_load writes w[w_idx] at the clock edge.
//   - w_idx >= K: write is ignored.
//   - A sample uses the weights present in the cycle it is accepted (stage 1 reads them combinationally).
//  Window: on acc, win[0] <= s_data and win[k] <= win[k-1].
//  Fill counter: increments on acc and saturates at K.
//   - Output is produced only for accepts occurring when count >= K-1, i.e. the first K-1 samples after reset/flush are warm-up.
//  Pipeline (all stages hold when stall):
//   - S1: p[k] <= w[k]*winNext[k], each product 2*DW; bias registered.
//   - S2: sum <= sext(bias) + sum of p[k], width ACC_W, exact (no overflow by GUARD rule).
//   - S3: r = (sum + 2^(FRAC-1)) >>> FRAC (round half up; no add when FRAC=0).
//     - Saturate r to OUT_W; set m_sat if clipped.
//     - If relu_en and r<0: m_data=0, m_sat=0.
//     - m_valid <= v2.
//  Latency: 3 cycles from acceptance edge to m_valid (no stall). Throughput: 1 sample/cycle.
//  Output hold: m_data, m_sat and m_valid stay stable while m_valid && !m_ready.
//  Simultaneous events:
//   - flush beats s_valid and w_load writes still occur.
//   - rst mid-stream discards all in-flight results.
// TESTING
//  T1 fill/latency:
//   - Stimulus: K=7, FRAC=0, all w=1, bias=0, stream 1..10 with m_ready=1.
//   - Response: first m_valid 3 cycles after 7th accept; m_data = 28,35,42,49.
//  T2 backpressure:
//   - Stimulus: T1 stream with m_ready=0 for 5 cycles mid-stream.
//   - Response: s_ready=0, m_data held, no sample lost or duplicated.
//  T3 saturation:
//   - Stimulus: FRAC=0, all w=0x7FFF, x=0x7FFF.
//   - Response: m_data=0x7FFF, m_sat=1.
//   - Stimulus: x=0x8001.
//   - Response: m_data=0x8000, m_sat=1.
//  T4 rounding:
//   - Stimulus: FRAC=8, w0=384, other w=0, x=1.
//   - Response: m_data=2.
//   - Stimulus: x=-1.
//   - Response: m_data=-1.
//  T5 ReLU/bias:
//   - Stimulus: FRAC=0, all w=-1, bias=5, x=1, relu_en=1.
//   - Response: m_data=0.
//   - Stimulus: same with relu_en=0.
//   - Response: m_data=-2.
//  T6 flush/reset/weight update:
//   - Stimulus: flush after 10 samples.
//   - Response: next output only after 7 new accepts.
//   - Stimulus: w_load mid-stream.
//   - Response: s_ready=0 that cycle; later samples use new weight.
//   - Stimulus: rst mid-stream.
//   - Response: all outputs 0.

Source files
------------

// File: rtl/conv1d_pe_stream.sv
// Streaming K-tap 1-D convolution PE: sliding window times runtime weights plus bias,
// then round, saturate and optional ReLU, over a 3-stage valid/ready pipeline.
module conv1d_pe_stream #(
  parameter int unsigned DW    = 16,
  parameter int unsigned K     = 7,
  parameter int unsigned GUARD = 4,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   w_load,
  input  logic [$clog2(K)-1:0]   w_idx,
  input  logic [DW-1:0]          w_data,
  input  logic [DW-1:0]          bias,
  input  logic                   relu_en,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DW-1:0]          s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [OUT_W-1:0]       m_data,
  output logic                   m_sat
);

  localparam int unsigned CW    = $clog2(K + 1);
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned ACC_W = 2 * DW + GUARD;

  // Rounding and clip limits live one bit wider than the accumulator so the
  // half-LSB add can never wrap.
  localparam logic signed [ACC_W:0] RND =
      (FRAC > 0) ? ((ACC_W + 1)'(1) << (FRAC - 1)) : '0;
  localparam logic signed [ACC_W:0] OMAX =
      {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN = ~OMAX;

  logic signed [DW-1:0]    w_q    [K];
  logic signed [DW-1:0]    win_q  [K];
  logic signed [DW-1:0]    win_nx [K];
  logic signed [PW-1:0]    p_q    [K];
  logic [CW-1:0]           cnt_q;
  logic signed [DW-1:0]    b1_q;
  logic                    v1_q, v2_q;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic signed [ACC_W:0]   rnd;
  logic [OUT_W-1:0]        m_data_d;
  logic                    m_sat_d;
  logic                    adv, acc;

  assign adv     = !(m_valid && !m_ready);
  assign s_ready = !rst && adv && !w_load && !flush;
  assign acc     = s_valid && s_ready;

  always_comb begin
    win_nx[0] = s_data;
    for (int k = 1; k < int'(K); k++) win_nx[k] = win_q[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(K); k++) w_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(K); k++) begin
        if (w_load && int'(w_idx) == k) w_q[k] <= w_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(K); k++) win_q[k] <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      for (int k = 0; k < int'(K); k++) win_q[k] <= '0;
      cnt_q <= '0;
    end else if (acc) begin
      win_q <= win_nx;
      if (cnt_q != CW'(K)) cnt_q <= cnt_q + CW'(1);
    end
  end

  // Stage 1: products against the window as it will look after this accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(K); k++) p_q[k] <= '0;
      b1_q <= '0;
      v1_q <= 1'b0;
    end else if (flush) begin
      v1_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < int'(K); k++) p_q[k] <= PW'(w_q[k]) * PW'(win_nx[k]);
      b1_q <= bias;
      v1_q <= acc && (cnt_q >= CW'(K - 1));
    end
  end

  always_comb begin
    sum_d = ACC_W'(b1_q);
    for (int k = 0; k < int'(K); k++) sum_d = sum_d + ACC_W'(p_q[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      v2_q  <= 1'b0;
    end else if (flush) begin
      v2_q <= 1'b0;
    end else if (adv) begin
      sum_q <= sum_d;
      v2_q  <= v1_q;
    end
  end

  always_comb begin
    rnd      = ($signed((ACC_W + 1)'(sum_q)) + RND) >>> FRAC;
    m_data_d = rnd[OUT_W-1:0];
    m_sat_d  = 1'b0;
    if (rnd > OMAX) begin
      m_data_d = OMAX[OUT_W-1:0];
      m_sat_d  = 1'b1;
    end else if (rnd < OMIN) begin
      m_data_d = OMIN[OUT_W-1:0];
      m_sat_d  = 1'b1;
    end
    if (relu_en && rnd[ACC_W]) begin
      m_data_d = '0;
      m_sat_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sat   <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (adv) begin
      m_valid <= v2_q;
      m_data  <= m_data_d;
      m_sat   <= m_sat_d;
    end
  end

endmodule

// File: tb/tb_conv1d_pe_stream.sv
// Bench for conv1d_pe_stream: two instances (FRAC=0 and FRAC=8) share stimulus and are
// compared every cycle against a latency/scoreboard model of the convolution.
module tb_conv1d_pe_stream;

  localparam int K = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        w_load = 1'b0;
  logic [2:0]  w_idx = '0;
  logic [15:0] w_data = '0;
  logic [15:0] bias = '0;
  logic        relu_en = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        m_ready = 1'b1;
  logic        s_ready0, s_ready8, m_valid0, m_valid8, m_sat0, m_sat8;
  logic [15:0] m_data0, m_data8;

  always #5 clk = ~clk;

  conv1d_pe_stream #(.DW(16), .K(K), .GUARD(4), .FRAC(0), .OUT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .w_load(w_load), .w_idx(w_idx), .w_data(w_data),
    .bias(bias), .relu_en(relu_en), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_sat(m_sat0)
  );

  conv1d_pe_stream #(.DW(16), .K(K), .GUARD(4), .FRAC(8), .OUT_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .flush(flush), .w_load(w_load), .w_idx(w_idx), .w_data(w_data),
    .bias(bias), .relu_en(relu_en), .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data),
    .m_valid(m_valid8), .m_ready(m_ready), .m_data(m_data8), .m_sat(m_sat8)
  );

  typedef struct {
    longint sum;
    int     rem;
    longint d0;
    longint d8;
    bit     s0;
    bit     s8;
  } item_t;

  int     n_checks = 0;
  int     n_errors = 0;
  longint wm [K];
  longint win[$];
  int     cnt;
  item_t  q[$];
  longint log0[$], log8[$];
  bit     ls0[$];
  bit     last_acc;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // Reference: round half up by FRAC, clip to 16 bits, ReLU on the rounded value.
  function automatic void fin(input longint sum, input int f, input bit relu,
                              output longint d, output bit s);
    longint r;
    r = (f > 0) ? ((sum + (longint'(1) <<< (f - 1))) >>> f) : sum;
    s = 1'b0;
    if (r > 32767) begin d = 32767; s = 1'b1; end
    else if (r < -32768) begin d = -32768; s = 1'b1; end
    else d = r;
    if (relu && r < 0) begin d = 0; s = 1'b0; end
  endfunction

  task automatic model_clear(input bit weights);
    q.delete();
    win.delete();
    cnt = 0;
    if (weights) for (int k = 0; k < K; k++) wm[k] = 0;
  endtask

  task automatic cycle();
    bit exp_v, stall, exp_ready, accept;
    longint s, d;
    bit sb;
    @(negedge clk);
    exp_v     = (q.size() > 0) && (q[0].rem == 0);
    stall     = exp_v && !m_ready;
    exp_ready = !rst && !stall && !w_load && !flush;
    accept    = s_valid && exp_ready;
    last_acc  = accept;
    check("s_ready0", s_ready0, exp_ready);
    check("s_ready8", s_ready8, exp_ready);
    check("m_valid0", m_valid0, exp_v);
    check("m_valid8", m_valid8, exp_v);
    if (exp_v) begin
      check("m_data0", sx(m_data0), q[0].d0);
      check("m_sat0", m_sat0, q[0].s0);
      check("m_data8", sx(m_data8), q[0].d8);
      check("m_sat8", m_sat8, q[0].s8);
    end
    if (m_valid0 && m_ready) begin
      log0.push_back(sx(m_data0));
      ls0.push_back(m_sat0);
    end
    if (m_valid8 && m_ready) log8.push_back(sx(m_data8));
    @(posedge clk);
    if (flush) begin
      model_clear(1'b0);
    end else begin
      if (!stall) begin
        if (exp_v) void'(q.pop_front());
        foreach (q[i]) begin
          q[i].rem--;
          if (q[i].rem == 0) begin
            fin(q[i].sum, 0, relu_en, d, sb); q[i].d0 = d; q[i].s0 = sb;
            fin(q[i].sum, 8, relu_en, d, sb); q[i].d8 = d; q[i].s8 = sb;
          end
        end
      end
      if (accept) begin
        win.push_front(sx(s_data));
        if (win.size() > K) void'(win.pop_back());
        if (cnt >= K - 1) begin
          s = sx(bias);
          foreach (win[i]) s += wm[i] * win[i];
          q.push_back('{s, 2, 0, 0, 1'b0, 1'b0});
        end
        if (cnt < K) cnt++;
      end
    end
    if (w_load && w_idx < 3'(K)) wm[w_idx] = sx(w_data);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_s_ready0", s_ready0, 0);
    check("rst_m_valid0", m_valid0, 0);
    check("rst_m_data0", m_data0, 0);
    check("rst_m_sat0", m_sat0, 0);
    check("rst_s_ready8", s_ready8, 0);
    check("rst_m_valid8", m_valid8, 0);
    check("rst_m_data8", m_data8, 0);
    check("rst_m_sat8", m_sat8, 0);
    model_clear(1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; flush = 1'b0; w_load = 1'b0; m_ready = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic load_w(input int idx, input logic [15:0] v);
    w_load = 1'b1; w_idx = 3'(idx); w_data = v;
    cycle();
    w_load = 1'b0;
  endtask

  task automatic load_all(input logic [15:0] v);
    for (int k = 0; k < K; k++) load_w(k, v);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic send(input logic [15:0] x);
    int n = 0;
    s_valid = 1'b1; s_data = x;
    do begin cycle(); n++; end while (!last_acc && n < 50);
    if (!last_acc) check("send_accept", last_acc, 1);
    s_valid = 1'b0;
  endtask

  task automatic clear_logs();
    log0.delete(); log8.delete(); ls0.delete();
  endtask

  initial begin
    longint t1_exp [4];
    int idx, cyc, n;
    t1_exp = '{28, 35, 42, 49};
    do_reset();

    // Fill and latency, then the same stream under backpressure.
    load_all(16'd1);
    bias = '0; relu_en = 1'b0;
    clear_logs();
    for (int i = 1; i <= 10; i++) send(16'(i));
    idle(6);
    check("t1_count", log0.size(), 4);
    for (int i = 0; i < 4 && i < log0.size(); i++) check("t1_data", log0[i], t1_exp[i]);

    do_flush();
    clear_logs();
    idx = 1; cyc = 0;
    while (idx <= 10 && cyc < 60) begin
      s_valid = 1'b1; s_data = 16'(idx);
      m_ready = !(cyc >= 9 && cyc < 14);
      cycle();
      if (last_acc) idx++;
      cyc++;
    end
    idle(8);
    check("t2_count", log0.size(), 4);
    for (int i = 0; i < 4 && i < log0.size(); i++) check("t2_data", log0[i], t1_exp[i]);

    // Saturation both ways.
    do_flush();
    clear_logs();
    load_all(16'h7FFF);
    repeat (7) send(16'h7FFF);
    idle(4);
    check("t3_count", log0.size(), 1);
    if (log0.size() > 0) begin
      check("t3_pos_data", log0[$], 32767);
      check("t3_pos_sat", ls0[$], 1);
    end
    repeat (7) send(16'h8001);
    idle(4);
    if (log0.size() > 0) begin
      check("t3_neg_data", log0[$], -32768);
      check("t3_neg_sat", ls0[$], 1);
    end

    // Rounding on the FRAC=8 instance.
    do_flush();
    clear_logs();
    load_w(0, 16'd384);
    for (int k = 1; k < K; k++) load_w(k, 16'd0);
    repeat (7) send(16'd1);
    idle(4);
    check("t4_count", log8.size(), 1);
    if (log8.size() > 0) check("t4_pos", log8[$], 2);
    send(16'hFFFF);
    idle(4);
    if (log8.size() > 0) check("t4_neg", log8[$], -1);

    // ReLU and bias.
    do_flush();
    clear_logs();
    load_all(16'hFFFF);
    bias = 16'd5; relu_en = 1'b1;
    repeat (7) send(16'd1);
    idle(4);
    check("t5_count", log0.size(), 1);
    if (log0.size() > 0) begin
      check("t5_relu_data", log0[$], 0);
      check("t5_relu_sat", ls0[$], 0);
    end
    relu_en = 1'b0;
    send(16'd1);
    idle(4);
    if (log0.size() > 0) check("t5_norelu", log0[$], -2);

    // Flush warm-up, weight update mid-stream, reset mid-stream.
    do_flush();
    clear_logs();
    load_all(16'd1);
    bias = '0;
    repeat (10) send(16'($urandom_range(200)) - 16'd100);
    idle(4);
    do_flush();
    n = log0.size();
    repeat (6) send(16'd2);
    idle(5);
    check("t6_warmup", log0.size(), n);
    send(16'd2);
    idle(5);
    check("t6_first", log0.size(), n + 1);
    if (log0.size() > 0) check("t6_first_data", log0[$], 14);
    s_valid = 1'b1; s_data = 16'd2;
    w_load = 1'b1; w_idx = 3'd2; w_data = 16'd10;
    cycle();
    w_load = 1'b0;
    send(16'd2);
    idle(5);
    if (log0.size() > 0) check("t6_new_weight", log0[$], 32);
    repeat (4) send(16'd3);
    n = log0.size();
    do_reset();
    idle(6);
    check("t6_rst_discard", log0.size(), n);

    // Randomised traffic, including out-of-range weight indices.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      s_valid = ($urandom_range(99) < 80);
      s_data  = 16'($urandom);
      bias    = 16'($urandom);
      m_ready = ($urandom_range(99) < 70);
      w_load  = ($urandom_range(99) < 5);
      w_idx   = 3'($urandom_range(7));
      w_data  = 16'($urandom);
      flush   = ($urandom_range(99) < 2);
      if ($urandom_range(99) < 10) relu_en = ~relu_en;
      cycle();
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
